// File: rtl/pipe_stage_skid_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_pkg : occupancy encodings and per-boundary stage widths          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package pipe_pkg;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_FULL  = 2'd2;

   // Default widths per stage boundary: decode/execute, execute/memory, memory/writeback
   localparam int DE_CTRL_W = 16;
   localparam int DE_DATA_W = 24;
   localparam int EM_CTRL_W = 12;
   localparam int EM_DATA_W = 40;
   localparam int MW_CTRL_W = 8;
   localparam int MW_DATA_W = 40;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_skid_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stage_skid_if : valid/ready handshake into and out of a stage    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface pipe_stage_skid_if #(
   parameter int CTRL_W = 16,
   parameter int DATA_W = 24
);
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;

   modport master (
      output in_valid, in_ctrl, in_data, out_ready,
      input  in_ready, out_valid, out_ctrl, out_data
   );

   modport slave (
      input  in_valid, in_ctrl, in_data, out_ready,
      output in_ready, out_valid, out_ctrl, out_data
   );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid_perf_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_perf_cnt : saturating event counter, cleared only by reset       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pipe_perf_cnt #(
   parameter int CNT_W = 16
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             i_inc,
   output logic      [CNT_W-1:0] o_cnt
);
   localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_cnt <= '0;
      else if (i_inc && (r_cnt != '1))
         r_cnt <= r_cnt + C_ONE;
   end

   assign o_cnt = r_cnt;
endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stage_skid : pipeline stage register with 2-entry skid buffer,  |
// | registered ready; perf counters under PIPE_STAGE_PERF_EN. Rev 1.0     |
// +----------------------------------------------------------------------+
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int CTRL_W         = DE_CTRL_W,
   parameter int DATA_W         = DE_DATA_W,
   parameter bit FLUSH_DATA_CLR = 1'b1,
   parameter int CNT_W          = 16
) (
   input  wire logic       clk,
   input  wire logic       reset,
   input  wire logic       i_flush,
   pipe_stage_skid_if.slave pipe,
   output logic [1:0]      o_occupancy
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_bubble_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
`endif
);
   logic              r_main_valid;
   logic [CTRL_W-1:0] r_main_ctrl;
   logic [DATA_W-1:0] r_main_data;
   logic              r_skid_valid;
   logic [CTRL_W-1:0] r_skid_ctrl;
   logic [DATA_W-1:0] r_skid_data;
   logic              w_accept;
   logic              w_drain;

   // Ready depends only on skid state, so there is no combinational path from out_ready.
   assign w_accept = pipe.in_valid & ~r_skid_valid;
   assign w_drain  = r_main_valid & pipe.out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_main_valid <= 1'b0;
         r_main_ctrl  <= '0;
         r_main_data  <= '0;
         r_skid_valid <= 1'b0;
         r_skid_ctrl  <= '0;
         r_skid_data  <= '0;
      end else if (i_flush) begin
         r_main_valid <= 1'b0;
         r_main_ctrl  <= '0;
         r_skid_valid <= 1'b0;
         r_skid_ctrl  <= '0;
         if (FLUSH_DATA_CLR) begin
            r_main_data <= '0;
            r_skid_data <= '0;
         end
      end else if (!r_main_valid) begin
         if (w_accept) begin
            r_main_valid <= 1'b1;
            r_main_ctrl  <= pipe.in_ctrl;
            r_main_data  <= pipe.in_data;
         end
      end else if (!r_skid_valid) begin
         if (w_accept && w_drain) begin
            r_main_ctrl <= pipe.in_ctrl;
            r_main_data <= pipe.in_data;
         end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_ctrl  <= pipe.in_ctrl;
            r_skid_data  <= pipe.in_data;
         end else if (w_drain) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
         end
      end else if (w_drain) begin
         r_main_ctrl  <= r_skid_ctrl;
         r_main_data  <= r_skid_data;
         r_skid_valid <= 1'b0;
         r_skid_ctrl  <= '0;
      end
   end

   assign pipe.in_ready  = ~r_skid_valid;
   assign pipe.out_valid = r_main_valid;
   assign pipe.out_ctrl  = r_main_ctrl;
   assign pipe.out_data  = r_main_data;

   always_comb begin
      o_occupancy = OCC_EMPTY;
      if (r_skid_valid)
         o_occupancy = OCC_FULL;
      else if (r_main_valid)
         o_occupancy = OCC_ONE;
   end

`ifdef PIPE_STAGE_PERF_EN
   pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .i_inc (r_main_valid & ~pipe.out_ready),
      .o_cnt (o_stall_cnt)
   );

   pipe_perf_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .i_inc (~r_main_valid),
      .o_cnt (o_bubble_cnt)
   );

   pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .i_inc (i_flush),
      .o_cnt (o_flush_cnt)
   );
`endif
endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_stage_skid : directed self-checking bench for pipe_stage_skid |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_pipe_stage_skid;
   localparam int CTRL_W = 16;
   localparam int DATA_W = 24;
   localparam int CNT_W  = 4;

   logic       clk;
   logic       reset;
   logic       flush;
   logic [1:0] occ;
   int         n_vec;
   int         n_err;
`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] bubble_cnt;
   logic [CNT_W-1:0] flush_cnt;
`endif

   pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) bus ();

   pipe_stage_skid #(
      .CTRL_W         (CTRL_W),
      .DATA_W         (DATA_W),
      .FLUSH_DATA_CLR (1'b1),
      .CNT_W          (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i_flush      (flush),
      .pipe         (bus.slave),
      .o_occupancy  (occ)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .o_stall_cnt  (stall_cnt),
      .o_bubble_cnt (bubble_cnt),
      .o_flush_cnt  (flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] c, input logic [23:0] d);
      bus.in_valid = v;
      bus.in_ctrl  = c;
      bus.in_data  = d;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      flush = 1'b0;
      bus.out_ready = 1'b0;
      drive(1'b0, 16'h0, 24'h0);
      #2 reset = 1'b0;
      #1;
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_ctrl",  32'(bus.out_ctrl),  32'd0);
      chk("rst_out_data",  32'(bus.out_data),  32'd0);
      chk("rst_occ",       32'(occ),           32'd0);
      step();
      reset = 1'b1;

      // Streaming at full rate: each beat appears one edge after acceptance.
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, 16'(i), 24'(i));
         step();
         chk("stream_valid", 32'(bus.out_valid), 32'd1);
         chk("stream_data",  32'(bus.out_data),  32'(i));
         chk("stream_occ",   32'(occ),           32'd1);
      end
      drive(1'b0, 16'h0, 24'h0);
      step();
      chk("stream_end_valid", 32'(bus.out_valid), 32'd0);
      chk("stream_end_ctrl",  32'(bus.out_ctrl),  32'd0);
      chk("stream_end_data",  32'(bus.out_data),  32'h5);

      // Backpressure fills the skid, then drains in order.
      drive(1'b1, 16'h10, 24'h10);
      step();
      chk("bp_first", 32'(bus.out_data), 32'h10);
      bus.out_ready = 1'b0;
      drive(1'b1, 16'h11, 24'h11);
      step();
      chk("bp_occ2",     32'(occ),          32'd2);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      drive(1'b1, 16'h12, 24'h12);
      step();
      chk("bp_hold_occ",  32'(occ),          32'd2);
      chk("bp_hold_data", 32'(bus.out_data), 32'h10);
      bus.out_ready = 1'b1;
      step();
      chk("bp_drain1_data",  32'(bus.out_data), 32'h11);
      chk("bp_drain1_ready", 32'(bus.in_ready), 32'd1);
      chk("bp_drain1_occ",   32'(occ),          32'd1);
      step();
      chk("bp_drain2_data", 32'(bus.out_data),  32'h12);
      chk("bp_drain2_ctrl", 32'(bus.out_ctrl),  32'h12);
      drive(1'b0, 16'h0, 24'h0);
      step();
      chk("bp_empty", 32'(bus.out_valid), 32'd0);

      // Flush while full, with a competing accept that must be discarded.
      bus.out_ready = 1'b0;
      drive(1'b1, 16'hFFFF, 24'h20);
      step();
      drive(1'b1, 16'hFFFF, 24'h21);
      step();
      chk("fl_pre_occ", 32'(occ), 32'd2);
      flush = 1'b1;
      drive(1'b1, 16'hFFFF, 24'h33);
      step();
      chk("fl_valid",    32'(bus.out_valid), 32'd0);
      chk("fl_ctrl",     32'(bus.out_ctrl),  32'd0);
      chk("fl_occ",      32'(occ),           32'd0);
      chk("fl_in_ready", 32'(bus.in_ready),  32'd1);
      chk("fl_data_clr", 32'(bus.out_data),  32'd0);
      flush = 1'b0;
      drive(1'b0, 16'h0, 24'h0);
      step();
      chk("fl_no_ghost", 32'(bus.out_valid), 32'd0);

      // Bubble after a single beat: ctrl clears, data holds.
      bus.out_ready = 1'b1;
      drive(1'b1, 16'h00A5, 24'h55);
      step();
      chk("bub_ctrl_live", 32'(bus.out_ctrl), 32'h00A5);
      drive(1'b0, 16'h0, 24'h0);
      step();
      chk("bub_valid", 32'(bus.out_valid), 32'd0);
      chk("bub_ctrl",  32'(bus.out_ctrl),  32'd0);
      chk("bub_data",  32'(bus.out_data),  32'h55);

      // Asynchronous reset while stalled full.
      bus.out_ready = 1'b0;
      drive(1'b1, 16'h40, 24'h40);
      step();
      drive(1'b1, 16'h41, 24'h41);
      step();
      chk("ar_pre_occ", 32'(occ), 32'd2);
      drive(1'b0, 16'h0, 24'h0);
      #2 reset = 1'b0;
      #1;
      chk("ar_valid",    32'(bus.out_valid), 32'd0);
      chk("ar_ctrl",     32'(bus.out_ctrl),  32'd0);
      chk("ar_data",     32'(bus.out_data),  32'd0);
      chk("ar_occ",      32'(occ),           32'd0);
      chk("ar_in_ready", 32'(bus.in_ready),  32'd1);
      step();
      reset = 1'b1;

`ifdef PIPE_STAGE_PERF_EN
      drive(1'b1, 16'h1, 24'h1);
      step();
      drive(1'b0, 16'h0, 24'h0);
      for (int i = 0; i < 20; i++) step();
      chk("perf_stall_sat", 32'(stall_cnt), 32'd15);
      flush = 1'b1;
      for (int i = 0; i < 3; i++) step();
      flush = 1'b0;
      step();
      chk("perf_flush", 32'(flush_cnt), 32'd3);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register, the next-generation replacement for the fixed-field inter-stage latches (decode→execute and similar). Carries a flush-cleared control vector plus an operand/data vector between stages under a valid/ready handshake, with a 2-entry skid buffer. Downstream stalls propagate upstream without a combinational ready path, and full throughput is sustained. Sits between any two pipeline stages of the processor.

## Interface
- CTRL_W, 16: control bits (RW, MW, ALU op, branch, halt, hazard tags…); forced to 0 on flush and in bubbles.
- DATA_W, 24: operand/register-index bits; held through bubbles.
- FLUSH_DATA_CLR, 1: 1 = flush also zeroes data; 0 = data left untouched.
- CNT_W, 16: width of the performance counters (only with PIPE_STAGE_PERF_EN).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream has a beat.
- in_ready  out  1  stage can accept; registered (= !skid_valid).
- in_ctrl  in  CTRL_W  upstream control.
- in_data  in  DATA_W  upstream data.
- out_valid  out  1  main entry holds a beat.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  main entry control; 0 whenever out_valid=0.
- out_data  out  DATA_W  main entry data.
- occupancy  out  2  entries held, 0–2.
- stall_cnt, bubble_cnt, flush_cnt  out  CNT_W each  perf counters (PIPE_STAGE_PERF_EN only).

## Operation
- Two entries: main (drives outputs) and skid. Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- occupancy 0: accept → load main.
- occupancy 1: accept & drain → main reloads from input. Accept & !drain → input goes to skid. Drain & !accept → main empties, out_ctrl cleared to 0, out_data held.
- occupancy 2: in_ready=0, no accept. Drain → skid moves to main, skid empties.
- Never occupancy >2. Order is strictly preserved. A beat is never dropped or duplicated.
- flush: clears main and skid valid, zeroes out_ctrl and skid ctrl. Zeroes data only when FLUSH_DATA_CLR=1. Flush dominates: a same-cycle accept is discarded, and a same-cycle drain still counts downstream, but the entry does not persist.
- reset (async): all valids 0, out_ctrl 0, out_data 0, occupancy 0, counters 0. in_ready reads 1 while in reset. Reset mid-transfer drops all held beats.

## Timing
- Latency: in→out 1 cycle when empty (accept at edge N, out_valid high after edge N).
- Throughput 1 beat/cycle with out_ready held high.
- in_ready is registered. It falls the cycle after the skid fills and rises the cycle after the skid drains or a flush occurs.
- in_ctrl/in_data are sampled only on accept. Held outputs are stable while out_valid & !out_ready.
- Flush takes effect at the same edge. out_valid=0 and in_ready=1 in the following cycle.

## Configuration
- PIPE_STAGE_PERF_EN defined: three saturating CNT_W counters, cleared only by reset.
  - stall_cnt increments per cycle with out_valid & !out_ready.
  - bubble_cnt increments per cycle with !out_valid.
  - flush_cnt increments per flush cycle.
  - Each counter stops at all-ones.
- Not defined: counter ports and logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package pipe_pkg holds:
  - occupancy constants OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2;
  - default CTRL_W/DATA_W localparams per stage boundary (DE, EM, MW).
- One sub-module, pipe_perf_cnt: a single saturating counter with increment enable, instantiated three times under the macro.

## Test plan
- Reset then stream: reset low→high; in_valid=1, out_ready=1, data 0x01..0x05 on successive cycles → out_data 0x01..0x05, one cycle later each, no gaps, occupancy 1.
- Backpressure: out_ready=0 after beat 0x10, send 0x11, 0x12 → occupancy 2, in_ready=0, 0x12 not accepted. out_ready=1 → outputs 0x10, 0x11, then 0x12 accepted and delivered in order.
- Flush while full: occupancy 2, ctrl=0xFFFF, assert flush with in_valid=1 (data 0x33) → next cycle out_valid=0, out_ctrl=0, occupancy 0, in_ready=1, 0x33 never appears. With FLUSH_DATA_CLR=1, out_data=0.
- Bubble ctrl clear: single beat ctrl=0x00A5 drained with no follow-on → out_ctrl=0 while out_valid=0, out_data retains the last value.
- Async reset mid-stall: occupancy 2, drop reset between edges → outputs zero immediately, occupancy 0.
- Perf (PIPE_STAGE_PERF_EN, CNT_W=4): 20 stall cycles → stall_cnt=15 (saturated). 3 flushes → flush_cnt=3.
